// File: rtl/rfile_sb.sv
// Register file with per-register busy scoreboard, two read ports and one write port.
// Reads are combinational with a same-cycle writeback bypass; writes and busy bits update on the Clk edge.
// Stall is raised combinationally on RAW/WAW hazards; an issue is not accepted while Stall is high.
module rfile_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Run,
    input  logic [ADDR_W-1:0] Rs,
    input  logic [ADDR_W-1:0] Rt,
    input  logic              ReadEnA,
    input  logic              ReadEnB,
    output logic [DATA_W-1:0] busA,
    output logic [DATA_W-1:0] busB,
    input  logic              RegWr,
    input  logic [ADDR_W-1:0] Rw,
    input  logic [DATA_W-1:0] busW,
    input  logic              Issue,
    input  logic [ADDR_W-1:0] IssueRd,
    output logic              Stall,
    output logic [ADDR_W:0]   PendCnt
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam bit ZR    = (ZERO_REG != 0);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic [DEPTH-1:0]  busy_nxt;

    logic wb_fire;
    logic is_fire;
    logic haz_a;
    logic haz_b;
    logic haz_i;
    logic is_sets;
    logic wb_clears;

    // Writeback qualification; register 0 is never written when hard-wired to zero
    assign wb_fire = Run & RegWr & ~(ZR & (Rw == '0));

    // Read ports: zero register first, then bypass from the writeback bus, then storage
    always_comb begin
        busA = mem[Rs];
        if (wb_fire && (Rw == Rs)) busA = busW;
        if (ZR && (Rs == '0))      busA = '0;
        busB = mem[Rt];
        if (wb_fire && (Rw == Rt)) busB = busW;
        if (ZR && (Rt == '0))      busB = '0;
    end

    // Hazard detection; a busy bit being cleared by this cycle's writeback is masked
    always_comb begin
        haz_a = busy[Rs]      & ~(wb_fire & (Rw == Rs));
        haz_b = busy[Rt]      & ~(wb_fire & (Rw == Rt));
        haz_i = busy[IssueRd] & ~(wb_fire & (Rw == IssueRd));
        Stall = Run & ((ReadEnA & haz_a) | (ReadEnB & haz_b) | (Issue & haz_i));
    end

    // Issue acceptance and the per-cycle pending-count contributions
    always_comb begin
        is_fire   = Run & Issue & ~Stall & ~(ZR & (IssueRd == '0));
        is_sets   = is_fire & (~busy[IssueRd] | (wb_fire & (Rw == IssueRd)));
        wb_clears = wb_fire & busy[Rw];
    end

    // Next busy vector: writeback clears, issue sets, set wins on the same register
    always_comb begin
        busy_nxt = busy;
        if (wb_fire) busy_nxt[Rw]      = 1'b0;
        if (is_fire) busy_nxt[IssueRd] = 1'b1;
    end

    // Storage, scoreboard and pending counter; asynchronous reset clears everything
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            busy    <= '0;
            PendCnt <= '0;
        end else begin
            if (wb_fire) mem[Rw] <= busW;
            busy    <= busy_nxt;
            PendCnt <= PendCnt + {{ADDR_W{1'b0}}, is_sets} - {{ADDR_W{1'b0}}, wb_clears};
        end
    end

endmodule

// File: tb/tb_rfile_sb.sv
// Self-checking bench for rfile_sb: directed vector table, async-reset sequence, random run.
// Every cycle is compared against a behavioural register-file/scoreboard model.
// PendCnt is checked against the population count of the model busy set.
module tb_rfile_sb;

    logic        Clk;
    logic        Rst;
    logic        Run;
    logic [4:0]  Rs, Rt, Rw, IssueRd;
    logic        ReadEnA, ReadEnB, RegWr, Issue;
    logic [31:0] busA, busB, busW;
    logic        Stall;
    logic [5:0]  PendCnt;

    rfile_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1)) dut (
        .Clk(Clk), .Rst(Rst), .Run(Run),
        .Rs(Rs), .Rt(Rt), .ReadEnA(ReadEnA), .ReadEnB(ReadEnB),
        .busA(busA), .busB(busB),
        .RegWr(RegWr), .Rw(Rw), .busW(busW),
        .Issue(Issue), .IssueRd(IssueRd),
        .Stall(Stall), .PendCnt(PendCnt)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          run;
        logic [4:0]  rs, rt;
        bit          rea, reb, regwr;
        logic [4:0]  rw;
        logic [31:0] busw;
        bit          iss;
        logic [4:0]  ird;
        logic [31:0] ea, eb;
        bit          est;
        logic [5:0]  ep;
    } vec_t;

    // behavioural model state
    logic [31:0] m_mem  [32];
    bit          m_busy [32];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int popcount();
        int n = 0;
        for (int i = 0; i < 32; i++) if (m_busy[i]) n++;
        return n;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_mem[i]  = 32'h0;
            m_busy[i] = 1'b0;
        end
    endtask

    function automatic vec_t mk(bit run, int rs, int rt, bit rea, bit reb, bit regwr, int rw,
                                logic [31:0] busw, bit iss, int ird,
                                logic [31:0] ea, logic [31:0] eb, bit est, int ep);
        vec_t v;
        v.run = run; v.rs = 5'(rs); v.rt = 5'(rt); v.rea = rea; v.reb = reb;
        v.regwr = regwr; v.rw = 5'(rw); v.busw = busw; v.iss = iss; v.ird = 5'(ird);
        v.ea = ea; v.eb = eb; v.est = est; v.ep = 6'(ep);
        return v;
    endfunction

    // Apply one cycle: drive, check combinational outputs, clock, check PendCnt.
    task automatic step(input vec_t v, input bit tbl, input int idx);
        bit          wbf, haz_a, haz_b, haz_i, st, isf;
        logic [31:0] ea, eb;
        Run = v.run; Rs = v.rs; Rt = v.rt; ReadEnA = v.rea; ReadEnB = v.reb;
        RegWr = v.regwr; Rw = v.rw; busW = v.busw; Issue = v.iss; IssueRd = v.ird;
        #1;
        wbf = v.run && v.regwr && (v.rw != 0);
        ea = (v.rs == 0) ? 32'h0 : (wbf && v.rw == v.rs) ? v.busw : m_mem[v.rs];
        eb = (v.rt == 0) ? 32'h0 : (wbf && v.rw == v.rt) ? v.busw : m_mem[v.rt];
        haz_a = m_busy[v.rs]  && !(wbf && v.rw == v.rs);
        haz_b = m_busy[v.rt]  && !(wbf && v.rw == v.rt);
        haz_i = m_busy[v.ird] && !(wbf && v.rw == v.ird);
        st  = v.run && ((v.rea && haz_a) || (v.reb && haz_b) || (v.iss && haz_i));
        isf = v.run && v.iss && !st && (v.ird != 0);
        chk($sformatf("busA[%0d]", idx), 64'(busA), 64'(ea));
        chk($sformatf("busB[%0d]", idx), 64'(busB), 64'(eb));
        chk($sformatf("stall[%0d]", idx), 64'(Stall), 64'(st));
        if (tbl) begin
            chk($sformatf("tbl_busA[%0d]", idx), 64'(busA), 64'(v.ea));
            chk($sformatf("tbl_busB[%0d]", idx), 64'(busB), 64'(v.eb));
            chk($sformatf("tbl_stall[%0d]", idx), 64'(Stall), 64'(v.est));
        end
        @(posedge Clk);
        if (wbf) begin
            m_mem[v.rw]  = v.busw;
            m_busy[v.rw] = 1'b0;
        end
        if (isf) m_busy[v.ird] = 1'b1;
        #1;
        chk($sformatf("pend[%0d]", idx), 64'(PendCnt), 64'(popcount()));
        if (tbl) chk($sformatf("tbl_pend[%0d]", idx), 64'(PendCnt), 64'(v.ep));
        @(negedge Clk);
    endtask

    vec_t tv [17];
    vec_t r;

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //        run rs rt ra rb wr rw busw          is ird  expA          expB          st pend
        tv[0]  = mk(1, 5, 0, 0, 0, 1, 5, 32'hDEADBEEF, 0, 0,  32'hDEADBEEF, 32'h0,        0, 0);
        tv[1]  = mk(1, 5, 5, 0, 0, 0, 0, 32'h0,        0, 0,  32'hDEADBEEF, 32'hDEADBEEF, 0, 0);
        tv[2]  = mk(1, 0, 0, 0, 0, 1, 0, 32'h1234,     0, 0,  32'h0,        32'h0,        0, 0);
        tv[3]  = mk(1, 0, 5, 0, 0, 0, 0, 32'h0,        0, 0,  32'h0,        32'hDEADBEEF, 0, 0);
        tv[4]  = mk(1, 5, 0, 0, 0, 0, 0, 32'h0,        1, 7,  32'hDEADBEEF, 32'h0,        0, 1);
        tv[5]  = mk(1, 7, 0, 1, 0, 0, 0, 32'h0,        0, 0,  32'h0,        32'h0,        1, 1);
        tv[6]  = mk(1, 7, 0, 0, 0, 0, 0, 32'h0,        0, 0,  32'h0,        32'h0,        0, 1);
        tv[7]  = mk(1, 7, 0, 1, 0, 1, 7, 32'h55,       0, 0,  32'h55,       32'h0,        0, 0);
        tv[8]  = mk(1, 0, 0, 0, 0, 0, 0, 32'h0,        1, 3,  32'h0,        32'h0,        0, 1);
        tv[9]  = mk(1, 0, 0, 0, 0, 0, 0, 32'h0,        1, 3,  32'h0,        32'h0,        1, 1);
        tv[10] = mk(1, 3, 0, 1, 0, 1, 3, 32'h33,       1, 3,  32'h33,       32'h0,        0, 1);
        tv[11] = mk(1, 3, 0, 1, 0, 0, 0, 32'h0,        0, 0,  32'h33,       32'h0,        1, 1);
        tv[12] = mk(1, 9, 0, 0, 0, 1, 9, 32'h99,       0, 0,  32'h99,       32'h0,        0, 1);
        tv[13] = mk(0, 12, 3, 1, 1, 1, 12, 32'hAAAA,   1, 12, 32'h0,        32'h33,       0, 1);
        tv[14] = mk(1, 12, 0, 1, 0, 0, 0, 32'h0,       0, 0,  32'h0,        32'h0,        0, 1);
        tv[15] = mk(1, 0, 0, 0, 0, 0, 0, 32'h0,        1, 0,  32'h0,        32'h0,        0, 1);
        tv[16] = mk(1, 3, 0, 0, 0, 1, 3, 32'h44,       0, 0,  32'h44,       32'h0,        0, 0);

        // reset with quiet inputs
        Rst = 1'b1; Run = 1'b0; Rs = '0; Rt = '0; ReadEnA = 1'b0; ReadEnB = 1'b0;
        RegWr = 1'b0; Rw = '0; busW = '0; Issue = 1'b0; IssueRd = '0;
        model_reset();
        @(negedge Clk);
        @(negedge Clk);
        chk("reset_pend", 64'(PendCnt), 64'd0);
        Rst = 1'b0;

        // every address reads zero after reset, with both operands enabled and no stall
        Run = 1'b1; ReadEnA = 1'b1; ReadEnB = 1'b1;
        for (int a = 0; a < 32; a++) begin
            Rs = 5'(a); Rt = 5'(31 - a);
            #1;
            chk($sformatf("rst_busA[%0d]", a), 64'(busA), 64'd0);
            chk($sformatf("rst_busB[%0d]", a), 64'(busB), 64'd0);
            chk($sformatf("rst_stall[%0d]", a), 64'(Stall), 64'd0);
        end
        ReadEnA = 1'b0; ReadEnB = 1'b0;
        @(negedge Clk);

        for (int i = 0; i < 17; i++) step(tv[i], 1'b1, i);

        // issue r1, r2, r4 back to back, then reset asynchronously between edges
        step(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 1), 1'b1, 100);
        step(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0, 2), 1'b1, 101);
        step(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 4, 0, 0, 0, 3), 1'b1, 102);
        Run = 1'b1; Rs = 5'd5; Rt = 5'd2; ReadEnA = 1'b0; ReadEnB = 1'b1;
        RegWr = 1'b0; Issue = 1'b0;
        #1;
        chk("pre_arst_stall", 64'(Stall), 64'd1);
        chk("pre_arst_busA", 64'(busA), 64'hDEADBEEF);
        #1;
        Rst = 1'b1;
        #1;
        chk("arst_pend", 64'(PendCnt), 64'd0);
        chk("arst_stall", 64'(Stall), 64'd0);
        chk("arst_busA", 64'(busA), 64'd0);
        model_reset();
        @(negedge Clk);
        Rst = 1'b0;

        // writeback to a non-busy register right after reset release
        step(mk(1, 9, 0, 0, 0, 1, 9, 32'h0909, 0, 0, 32'h0909, 0, 0, 0), 1'b1, 103);

        // randomized traffic on a narrow address window to force collisions
        for (int n = 0; n < 3000; n++) begin
            r = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            r.run   = ($urandom_range(0, 9) != 0);
            r.rs    = 5'($urandom_range(0, 7));
            r.rt    = 5'($urandom_range(0, 7));
            r.rea   = 1'($urandom_range(0, 1));
            r.reb   = 1'($urandom_range(0, 1));
            r.regwr = 1'($urandom_range(0, 1));
            r.rw    = 5'($urandom_range(0, 7));
            r.busw  = $urandom;
            r.iss   = ($urandom_range(0, 2) != 0);
            r.ird   = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
            step(r, 1'b0, 1000 + n);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
